// File: rtl/sevenseg_scan_if.sv
// Bundles the scan controller's data, control and display signals.
// master: display user / board side (drives data, control and decoder segments)
// slave:  scan controller (drives decoder nibble, segments, anodes and status)
//   enable, load, value_in, dp_in, lz_suppress : control and display data
//   seg_in / hex_sel                           : shared hex-to-7-segment decoder
//   seg_out, dp_n, anode_n                     : active-low display drive
//   frame_done, pending                        : status
interface sevenseg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_suppress;
  logic [6:0]                seg_in;
  logic [3:0]                hex_sel;
  logic [6:0]                seg_out;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output enable, load, value_in, dp_in, lz_suppress, seg_in,
    input  hex_sel, seg_out, dp_n, anode_n, frame_done, pending
  );

  modport slave (
    input  enable, load, value_in, dp_in, lz_suppress, seg_in,
    output hex_sel, seg_out, dp_n, anode_n, frame_done, pending
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment digits
// sharing one external hex decoder. Each digit slot is REFRESH_DIV clocks: the first
// BLANK_CYCLES clocks keep all anodes off while the decoder settles, then the
// registered segments/anode for that digit are shown. Display data is double
// buffered: loads while scanning wait in pending registers until the frame wraps.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sevenseg_scan_if slave modport (control, data, decoder, display drive)
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic           clk,
  input logic           rst_n,
  sevenseg_scan_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;
  localparam logic [CntW-1:0] CntLast   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_q, frame_d;
  logic                  pend_q, pend_d;
  logic [ValW-1:0]       pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [ValW-1:0]       shad_val_q, shad_val_d;
  logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;

  logic                  wrap;
  logic                  boundary;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] supp_vec;
  logic [3:0]            cur_nib;
  logic                  cur_supp;

  // Digit i is a leading zero when it and every digit above it have a zero nibble
  // and an unlit decimal point; digit 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    supp_vec   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (shad_val_q[4*i +: 4] == 4'h0) & ~shad_dp_q[i];
      supp_vec[i] = bus.lz_suppress & zero_above & (i != 0);
    end
  end

  assign cur_nib  = shad_val_q[{idx_q, 2'b00} +: 4];
  assign cur_supp = supp_vec[idx_q];

  // Scan FSM: next state, slot position and registered display drive.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    dp_n_d  = dp_n_q;
    anode_d = anode_q;
    frame_d = 1'b0;
    wrap    = 1'b0;

    unique case (state_q)
      StIdle: begin
        seg_d   = 7'h7F;
        dp_n_d  = 1'b1;
        anode_d = '1;
        idx_d   = '0;
        cnt_d   = '0;
        if (bus.enable) state_d = StBlank;
      end
      StBlank: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          // Suppressed digits simply stay dark for their whole slot.
          if (!cur_supp) begin
            seg_d          = bus.seg_in;
            dp_n_d         = ~shad_dp_q[idx_q];
            anode_d        = '1;
            anode_d[idx_q] = 1'b0;
          end
        end
      end
      StShow: begin
        if (cnt_q == CntLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          seg_d   = 7'h7F;
          dp_n_d  = 1'b1;
          anode_d = '1;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            wrap    = 1'b1;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable wins over everything, including a frame wrap on the same edge.
    if (!bus.enable) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
      seg_d   = 7'h7F;
      dp_n_d  = 1'b1;
      anode_d = '1;
      frame_d = 1'b0;
      wrap    = 1'b0;
    end
  end

  // Double buffer. Shadow may only change where no digit is being shown from it:
  // at the frame wrap, when dropping back to idle, or while idle.
  always_comb begin
    boundary   = wrap | (state_q == StIdle) | ~bus.enable;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    if (boundary) begin
      pend_d = 1'b0;
      if (bus.load) begin
        shad_val_d = bus.value_in;
        shad_dp_d  = bus.dp_in;
      end else if (pend_q) begin
        shad_val_d = pend_val_q;
        shad_dp_d  = pend_dp_q;
      end
    end else if (bus.load) begin
      pend_d     = 1'b1;
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= 7'h7F;
      dp_n_q     <= 1'b1;
      anode_q    <= '1;
      frame_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
      anode_q    <= anode_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
    end
  end

  // Decoder sees the current digit's nibble from the first blank cycle on.
  assign bus.hex_sel    = (state_q == StIdle) ? 4'h0 : cur_nib;
  assign bus.seg_out    = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.anode_n    = anode_q;
  assign bus.frame_done = frame_q;
  assign bus.pending    = pend_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (4 digits, 8-clock slots, 2 blank clocks).
// The reference model tracks only "clocks since scanning started" plus the shadow and
// pending data; expected outputs are derived from that with plain arithmetic.
module tb_sevenseg_scan_ctrl;
  localparam int NumDigits   = 4;
  localparam int RefreshDiv  = 8;
  localparam int BlankCycles = 2;
  localparam int FrameLen    = NumDigits * RefreshDiv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sevenseg_scan_if #(.NUM_DIGITS(NumDigits)) bus ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (NumDigits),
    .REFRESH_DIV (RefreshDiv),
    .BLANK_CYCLES(BlankCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Shared external decoder.
  assign bus.seg_in = hex7(bus.hex_sel);

  int checks = 0;
  int errors = 0;

  bit          m_run;
  int          m_t;
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sd, m_pd;
  bit          m_pend;
  bit          m_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_sv = '0; m_pv = '0; m_sd = '0; m_pd = '0;
    m_pend = 0; m_frame = 0;
  endtask

  // Effect of one clock edge given the inputs applied to it.
  task automatic model_edge(input bit en, input bit ld, input logic [15:0] v,
                            input logic [3:0] dp);
    m_frame = 0;
    if (!m_run) begin
      if (ld) begin m_sv = v; m_sd = dp; end
      if (en) begin m_run = 1; m_t = 0; end
    end else if (!en) begin
      m_run = 0;
      m_t   = 0;
      if (ld) begin m_sv = v; m_sd = dp; end
      else if (m_pend) begin m_sv = m_pv; m_sd = m_pd; end
      m_pend = 0;
    end else begin
      m_t++;
      if (m_t % FrameLen == 0) begin
        m_frame = 1;
        if (ld) begin m_sv = v; m_sd = dp; end
        else if (m_pend) begin m_sv = m_pv; m_sd = m_pd; end
        m_pend = 0;
      end else if (ld) begin
        m_pend = 1; m_pv = v; m_pd = dp;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] e_anode, e_hex, nib;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d, pos;
    bit         supp, lit;
    if (!m_run) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_hex = 4'h0;
    end else begin
      d    = (m_t / RefreshDiv) % NumDigits;
      pos  = m_t % RefreshDiv;
      nib  = 4'((m_sv >> (4 * d)) & 16'hF);
      supp = bus.lz_suppress && (d != 0) && ((m_sv >> (4 * d)) == 0) && ((m_sd >> d) == 0);
      lit  = (pos >= BlankCycles) && !supp;
      e_hex   = nib;
      e_anode = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg   = lit ? hex7(nib) : 7'h7F;
      e_dp    = lit ? ~m_sd[d] : 1'b1;
    end
    chk("anode_n", bus.anode_n, e_anode);
    chk("seg_out", bus.seg_out, e_seg);
    chk("dp_n", bus.dp_n, e_dp);
    chk("hex_sel", bus.hex_sel, e_hex);
    chk("frame_done", bus.frame_done, m_frame);
    chk("pending", bus.pending, m_pend);
  endtask

  task automatic tick(input bit en, input bit ld, input logic [15:0] v, input logic [3:0] dp);
    bus.enable   = en;
    bus.load     = ld;
    bus.value_in = v;
    bus.dp_in    = dp;
    @(posedge clk);
    #1;
    model_edge(en, ld, v, dp);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  // Advance (at most one frame) until the frame position equals phase.
  task automatic run_until(input int phase);
    for (int k = 0; k < FrameLen && (m_t % FrameLen) != phase; k++)
      tick(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd;
    bit en, ld;
    logic [15:0] v;
    logic [3:0]  dp;

    bus.enable = 0; bus.load = 0; bus.value_in = '0; bus.dp_in = '0;
    bus.lz_suppress = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_anode", bus.anode_n, 4'hF);
    @(negedge clk) rst_n = 1'b1;

    // Load in idle together with enable: digit 0 slot shows '4'.
    tick(1'b1, 1'b1, 16'h1234, 4'h0);
    chk("t1_hex_first_blank", bus.hex_sel, 4'h4);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    chk("t1_blank2_anode", bus.anode_n, 4'hF);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    chk("t1_show_anode", bus.anode_n, 4'b1110);
    chk("t1_show_seg", bus.seg_out, 7'b0011001);
    run(5);

    // Two full frames: exactly two frame pulses.
    fd = 0;
    for (int k = 0; k < 57; k++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0);
      fd += int'(bus.frame_done);
    end
    chk("t2_frame_pulses", fd, 2);

    // Mid-frame load waits for the wrap; then two loads in one frame.
    run(10);
    tick(1'b1, 1'b1, 16'h00A0, 4'h0);
    chk("t3_pending_set", bus.pending, 1'b1);
    run_until(0);
    chk("t3_pending_clear", bus.pending, 1'b0);
    run(5);
    tick(1'b1, 1'b1, 16'h5678, 4'h3);
    run(3);
    tick(1'b1, 1'b1, 16'h9ABC, 4'h8);
    run_until(0);
    run(FrameLen);
    // Load exactly on the wrap edge goes straight to shadow.
    run_until(FrameLen - 1);
    tick(1'b1, 1'b1, 16'h0F0F, 4'h1);
    chk("t3_wrap_load_pending", bus.pending, 1'b0);
    run(FrameLen);

    // Leading-zero suppression.
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    bus.lz_suppress = 1'b1;
    tick(1'b0, 1'b1, 16'h0005, 4'h0);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    run(2);
    chk("t4_five_seg", bus.seg_out, 7'b0010010);
    run(8);
    chk("t4_digit1_dark", bus.anode_n, 4'hF);
    run_until(5);
    tick(1'b1, 1'b1, 16'h0000, 4'h0);
    run_until(0);
    run(FrameLen);
    run_until(7);
    tick(1'b1, 1'b1, 16'h0000, 4'b0100);
    run_until(0);
    run(FrameLen + 3);

    // Disable during digit 2 show, then restart.
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    bus.lz_suppress = 1'b0;
    tick(1'b1, 1'b1, 16'h4321, 4'h0);
    run_until(2 * RefreshDiv + 4);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    chk("t5_dark", bus.anode_n, 4'hF);
    chk("t5_no_frame", bus.frame_done, 1'b0);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    chk("t5_restart_hex", bus.hex_sel, 4'h1);
    run(3);
    chk("t5_restart_anode", bus.anode_n, 4'b1110);

    // Randomized traffic; lz only changes while idle.
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 63) != 0);
      ld = ($urandom_range(0, 9) == 0);
      v  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick(en, ld, v, dp);
      if (!m_run) bus.lz_suppress = 1'($urandom_range(0, 1));
    end

    // Asynchronous reset mid-show with pending data.
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    bus.lz_suppress = 1'b0;
    tick(1'b1, 1'b1, 16'h1357, 4'h0);
    run_until(4);
    tick(1'b1, 1'b1, 16'hBEEF, 4'h0);
    chk("t6_pending_before", bus.pending, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_dark", bus.anode_n, 4'hF);
    chk("t6_pending", bus.pending, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    run(2);
    chk("t6_shadow_zero", bus.seg_out, 7'h40);
    run(FrameLen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
